ata_sector_ctl: RTL

ATA_SECTOR_CTL -- requirements
Module: ata_sector_ctl

---
 rtl/ata_sector_ctl.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/ata_sector_ctl.sv
// Single-sector PIO read/write sequencer for an ATA register-cycle engine.
// Optional status-poll timeout is compiled in with `define ATA_TIMEOUT_EN.
module ata_sector_ctl #(
    parameter logic [23:0] POLL_LIMIT = 24'd10000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_start,
    input  logic        cmd_write,
    input  logic [27:0] cmd_lba,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  buf_addr,
    output logic        buf_we,
    output logic [15:0] buf_wdata,
    input  logic [15:0] buf_rdata,
    output logic        ata_rd,
    output logic        ata_wr,
    output logic [4:0]  ata_addr,
    output logic [15:0] ata_wdata,
    input  logic [15:0] ata_rdata,
    input  logic        ata_done
);

    typedef enum logic [3:0] {
        IDLE, WAIT_RDY, SET_CNT, SET_L0, SET_L1, SET_L2,
        SET_HD, SET_CMD, POLL_DRQ, XFER, POLL_END, FINISH
    } state_t;

    state_t      r_state;
    logic        r_busy, r_done, r_error;
    logic        r_rd, r_wr, r_buf_we;
    logic [4:0]  r_addr;
    logic [15:0] r_wdata, r_buf_wdata;
    logic [8:0]  r_cnt;
    logic        r_write;
    logic [27:0] r_lba;

    logic [2:0]  w_set_reg;
    logic [15:0] w_set_data;
    state_t      w_set_next;
    logic        w_poll_adv, w_poll_err;
    state_t      w_poll_to;

    wire w_bsy  = ata_rdata[7];
    wire w_drdy = ata_rdata[6];
    wire w_df   = ata_rdata[5];
    wire w_drq  = ata_rdata[3];
    wire w_err  = ata_rdata[0];

    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;
    assign ata_rd    = r_rd;
    assign ata_wr    = r_wr;
    assign ata_addr  = r_addr;
    assign ata_wdata = r_wdata;
    assign buf_we    = r_buf_we;
    assign buf_wdata = r_buf_wdata;
    assign buf_addr  = r_cnt[7:0];

    // Task-file register and value for each setup write
    always_comb begin
        w_set_reg  = 3'd0;
        w_set_data = '0;
        w_set_next = IDLE;
        case (r_state)
            SET_CNT: begin w_set_reg = 3'd2; w_set_data = 16'h0001;                        w_set_next = SET_L0;   end
            SET_L0:  begin w_set_reg = 3'd3; w_set_data = {8'h00, r_lba[7:0]};             w_set_next = SET_L1;   end
            SET_L1:  begin w_set_reg = 3'd4; w_set_data = {8'h00, r_lba[15:8]};            w_set_next = SET_L2;   end
            SET_L2:  begin w_set_reg = 3'd5; w_set_data = {8'h00, r_lba[23:16]};           w_set_next = SET_HD;   end
            SET_HD:  begin w_set_reg = 3'd6; w_set_data = {8'h00, 4'hE, r_lba[27:24]};     w_set_next = SET_CMD;  end
            SET_CMD: begin w_set_reg = 3'd7; w_set_data = r_write ? 16'h0030 : 16'h0020;   w_set_next = POLL_DRQ; end
            default: ;
        endcase
    end

    // Exit decision for a completed status read in the polling states
    always_comb begin
        w_poll_adv = 1'b0;
        w_poll_err = 1'b0;
        w_poll_to  = FINISH;
        case (r_state)
            WAIT_RDY: if (!w_bsy && w_drdy) begin
                w_poll_adv = 1'b1;
                w_poll_to  = SET_CNT;
            end
            POLL_DRQ: if (!w_bsy) begin
                if (w_err || w_df) begin
                    w_poll_adv = 1'b1;
                    w_poll_err = 1'b1;
                end else if (w_drq) begin
                    w_poll_adv = 1'b1;
                    w_poll_to  = XFER;
                end
            end
            POLL_END: if (!w_bsy) begin
                w_poll_adv = 1'b1;
                w_poll_err = w_err || w_df;
            end
            default: ;
        endcase
    end

`ifdef ATA_TIMEOUT_EN
    logic [23:0] r_poll;
    wire w_polling = (r_state == WAIT_RDY) || (r_state == POLL_DRQ) || (r_state == POLL_END);
`else
    if (POLL_LIMIT == 24'd0) begin : g_limit_unused
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_rd        <= 1'b0;
            r_wr        <= 1'b0;
            r_buf_we    <= 1'b0;
            r_addr      <= '1;
            r_wdata     <= '0;
            r_buf_wdata <= '0;
            r_cnt       <= '0;
            r_write     <= 1'b0;
            r_lba       <= '0;
`ifdef ATA_TIMEOUT_EN
            r_poll      <= '0;
`endif
        end else begin
            r_done   <= 1'b0;
            r_buf_we <= 1'b0;
`ifdef ATA_TIMEOUT_EN
            // Leaving the polling states always passes through a non-polling state
            if (!w_polling) r_poll <= '0;
`endif
            case (r_state)
                IDLE: if (cmd_start) begin
                    r_write <= cmd_write;
                    r_lba   <= cmd_lba;
                    r_busy  <= 1'b1;
                    r_error <= 1'b0;
                    r_state <= WAIT_RDY;
                end
                WAIT_RDY, POLL_DRQ, POLL_END: begin
                    if (!r_rd) begin
                        r_rd   <= 1'b1;
                        r_addr <= {2'b10, 3'd7};
                    end else if (ata_done) begin
                        r_rd <= 1'b0;
                        if (w_poll_adv) begin
                            r_state <= w_poll_to;
                            if (w_poll_err) r_error <= 1'b1;
                            if (w_poll_to == XFER) r_cnt <= '0;
                        end
`ifdef ATA_TIMEOUT_EN
                        else if (r_poll == POLL_LIMIT - 24'd1) begin
                            r_error <= 1'b1;
                            r_state <= FINISH;
                        end else begin
                            r_poll <= r_poll + 24'd1;
                        end
`endif
                    end
                end
                SET_CNT, SET_L0, SET_L1, SET_L2, SET_HD, SET_CMD: begin
                    if (!r_wr) begin
                        r_wr    <= 1'b1;
                        r_addr  <= {2'b10, w_set_reg};
                        r_wdata <= w_set_data;
                    end else if (ata_done) begin
                        r_wr    <= 1'b0;
                        r_state <= w_set_next;
                    end
                end
                XFER: begin
                    if (r_write) begin
                        if (!r_wr) begin
                            r_wr    <= 1'b1;
                            r_addr  <= {2'b10, 3'd0};
                            r_wdata <= buf_rdata;
                        end else if (ata_done) begin
                            r_wr  <= 1'b0;
                            r_cnt <= r_cnt + 9'd1;
                            if (r_cnt == 9'd255) r_state <= POLL_END;
                        end
                    end else begin
                        // Buffer strobe cycle sits between data reads; counter advances after it
                        if (r_buf_we) begin
                            r_cnt <= r_cnt + 9'd1;
                            if (r_cnt == 9'd255) r_state <= POLL_END;
                        end else if (!r_rd) begin
                            r_rd   <= 1'b1;
                            r_addr <= {2'b10, 3'd0};
                        end else if (ata_done) begin
                            r_rd        <= 1'b0;
                            r_buf_we    <= 1'b1;
                            r_buf_wdata <= ata_rdata;
                        end
                    end
                end
                FINISH: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
